pattern_gen: RTL and testbench
==============================

# pattern_gen

Parametrised frame pattern generator that replaces the fixed single-bar line source feeding the VGA pixel FIFO. On each vertical trigger it latches a mode, width and colour, then streams exactly H_ACTIVE×V_ACTIVE RGB565 pixels into the VGA FIFO, throttled by fifo_full. It sits in the `clk` domain between the frame control logic in `main` and the `vga` FIFO write port.

## Interface
- H_ACTIVE, 640, visible pixels per line (≥2)
- V_ACTIVE, 480, visible lines per frame (≥1)
- CHK_LOG2, 4, checker square size = 2^CHK_LOG2 pixels
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- trigger  input  1  start-of-frame pulse (vtrigger from vga)
- mode  input  2  0 SOLID, 1 BAR, 2 CHECKER, 3 GRADIENT; sampled on accepted trigger
- w  input  12  bar width in pixels; sampled on accepted trigger
- color  input  16  RGB565 colour; sampled on accepted trigger
- fifo_full  input  1  VGA FIFO cannot accept a write this cycle
- fifo_write  output  1  write strobe into VGA FIFO
- fifo_data  output  16  RGB565 pixel, valid when fifo_write=1
- busy  output  1  frame in progress
- frame_done  output  1  one-cycle pulse after the last pixel is written
- overrun  output  1  sticky: trigger arrived while busy

## Operation
- States: IDLE, RUN.
- IDLE: trigger=1 → latch mode/w/color, x=0, y=0, next state RUN.
- RUN: fifo_write = !fifo_full && !reset. Each write advances x; at x=H_ACTIVE-1, x wraps to 0 and y increments. A write at (H_ACTIVE-1, V_ACTIVE-1) → IDLE and frame_done=1 next cycle.
- fifo_full=1 in RUN: no write, counters hold, pixel unchanged.
- trigger in RUN (including the final-write cycle): ignored, overrun←1. Frame is never restarted.
- Pixel function of registered (x, y, latched params):
  - SOLID: color.
  - BAR: color if x < w_lat, else 16'h0000. w=0 → all black; w≥H_ACTIVE → all color.
  - CHECKER: color if x[CHK_LOG2]^y[CHK_LOG2]=0, else ~color.
  - GRADIENT: red=x[7:3], green=y[7:2], blue=x[7:3]^y[7:3]; color is ignored.
- x width = clog2(H_ACTIVE), y width = clog2(V_ACTIVE); no arithmetic overflow is possible inside a frame.
- Reset (any state): state=IDLE, x=y=0, latched params=0, busy=0, frame_done=0, overrun=0, fifo_write=0 in the reset cycle itself. A partially written frame is abandoned.

## Timing
- Trigger to first possible write: 1 cycle (trigger at cycle N, fifo_write can be 1 at N+1).
- fifo_data and fifo_write are combinational from registered state and fifo_full. Zero latency from fifo_full deassertion to write.
- Throughput: 1 pixel/cycle while fifo_full=0. A frame takes H_ACTIVE×V_ACTIVE write cycles plus stall cycles.
- busy=1 exactly while state=RUN.
- frame_done is a registered pulse, 1 cycle after the last write, coincident with busy=0.
- A trigger in the same cycle that busy falls is accepted.

## Configuration
- PATTERN_GEN_CHECKER_EN defined: CHECKER mode as specified.
- Not defined: mode 2 behaves as SOLID. The checker logic and the CHK_LOG2 dependency are removed. All other modes are unchanged.

## Structure
- Shared package `vga_pkg`: mode encodings (MODE_SOLID/BAR/CHECKER/GRADIENT), RGB565 field positions, default H_ACTIVE/V_ACTIVE.
- One sub-module, `pattern_pixel`: combinational (x, y, mode, w, color) → rgb. The top holds the FSM, counters, handshake and flags.

## Test plan
- H_ACTIVE=8, V_ACTIVE=4, fifo_full=0, mode=SOLID, color=16'hF800, trigger → exactly 32 writes of F800 on consecutive cycles. frame_done pulses once, 1 cycle after the 32nd write. busy is high for 32 cycles.
- mode=BAR, w=3, color=16'h07E0 → each 8-pixel line is 07E0,07E0,07E0,0000×5. Repeat with w=0 (all 0000) and w=12 (all 07E0).
- fifo_full toggled pseudo-randomly in SOLID/GRADIENT mode → still 32 writes, each pixel equals the model at its (x,y), and no write occurs while fifo_full=1.
- trigger reasserted mid-frame → overrun=1 and stays 1, the frame completes with the original params, and the next trigger after busy=0 starts a new frame. Check also trigger in the busy-falling cycle.
- Reset asserted at pixel 10 → fifo_write=0 in that cycle, all outputs are 0 the next cycle, and the next trigger produces a full 32-pixel frame from (0,0).
- CHK_LOG2=1, color=16'h001F, with and without PATTERN_GEN_CHECKER_EN → line 0 is 001F,001F,FFE0,FFE0,… when defined, and all 001F when not.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA definitions: pattern mode encodings, RGB565 field layout,
// default frame geometry and the pattern generator FSM state type.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID    = 2'd0,
    MODE_BAR      = 2'd1,
    MODE_CHECKER  = 2'd2,
    MODE_GRADIENT = 2'd3
  } pat_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } pg_state_e;

  localparam int unsigned RED_LSB = 11;
  localparam int unsigned RED_W   = 5;
  localparam int unsigned GRN_LSB = 5;
  localparam int unsigned GRN_W   = 6;
  localparam int unsigned BLU_LSB = 0;
  localparam int unsigned BLU_W   = 5;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;

  function automatic logic [15:0] rgb565(input logic [RED_W-1:0] r,
                                         input logic [GRN_W-1:0] g,
                                         input logic [BLU_W-1:0] b);
    logic [15:0] p;
    p = '0;
    p[RED_LSB +: RED_W] = r;
    p[GRN_LSB +: GRN_W] = g;
    p[BLU_LSB +: BLU_W] = b;
    return p;
  endfunction

endpackage

// File: rtl/pattern_gen_pixel.sv
// pattern_pixel: combinational (x, y, mode, w, color) -> RGB565 pixel.
// CHECKER mode exists only when PATTERN_GEN_CHECKER_EN is defined; otherwise mode 2 is SOLID.
module pattern_pixel
  import vga_pkg::*;
#(
  parameter int unsigned XW = 10,
  parameter int unsigned YW = 9
`ifdef PATTERN_GEN_CHECKER_EN
  , parameter int unsigned CHK_LOG2 = 4
`endif
) (
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  pat_mode_e     mode,
  input  logic [11:0]   w,
  input  logic [15:0]   color,
  output logic [15:0]   rgb
);

  logic [15:0] xe;
  logic [15:0] ye;
  logic [7:0]  xl;
  logic [7:0]  yl;
  logic        unused_bits;

  always_comb begin
    xe = 16'(x);
    ye = 16'(y);
    xl = xe[7:0];
    yl = ye[7:0];
    rgb = color;
    case (mode)
      MODE_SOLID:    rgb = color;
      MODE_BAR:      rgb = (xe < {4'b0000, w}) ? color : '0;
`ifdef PATTERN_GEN_CHECKER_EN
      MODE_CHECKER:  rgb = (xe[CHK_LOG2] ^ ye[CHK_LOG2]) ? ~color : color;
`endif
      MODE_GRADIENT: rgb = rgb565(xl[7:3], yl[7:2], xl[7:3] ^ yl[7:3]);
      default:       rgb = color;
    endcase
  end

  // Counter bits above the fields a given mode looks at are intentionally ignored.
  assign unused_bits = ^{xe, ye, xl, yl};

endmodule

// File: rtl/pattern_gen.sv
// pattern_gen: streams one H_ACTIVE x V_ACTIVE RGB565 frame into the VGA FIFO per trigger.
// Optional macro PATTERN_GEN_CHECKER_EN enables the CHECKER pattern (mode 2).
module pattern_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned CHK_LOG2 = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trigger,
  input  logic [1:0]  mode,
  input  logic [11:0] w,
  input  logic [15:0] color,
  input  logic        fifo_full,
  output logic        fifo_write,
  output logic [15:0] fifo_data,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun
);

  localparam int unsigned XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int unsigned YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  if (H_ACTIVE < 2 || V_ACTIVE < 1 || CHK_LOG2 > 15) begin : g_bad_param
    $error("pattern_gen: unsupported parameter set");
  end

  pg_state_e   state, state_n;
  logic [XW-1:0] x, x_n;
  logic [YW-1:0] y, y_n;
  pat_mode_e   mode_lat;
  logic [11:0] w_lat;
  logic [15:0] color_lat;
  logic        load;
  logic        last_write;
  logic        wr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n    = state;
    x_n        = x;
    y_n        = y;
    load       = 1'b0;
    last_write = 1'b0;
    wr         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (trigger) begin
          load    = 1'b1;
          x_n     = '0;
          y_n     = '0;
          state_n = ST_RUN;
        end
      end
      ST_RUN: begin
        // Write strobe is masked by reset so an abandoned frame never leaks a pixel.
        wr = !fifo_full && !reset;
        if (wr) begin
          if (x == X_LAST) begin
            x_n = '0;
            if (y == Y_LAST) begin
              y_n        = '0;
              last_write = 1'b1;
              state_n    = ST_IDLE;
            end else begin
              y_n = y + YW'(1);
            end
          end else begin
            x_n = x + XW'(1);
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x          <= '0;
      y          <= '0;
      mode_lat   <= MODE_SOLID;
      w_lat      <= '0;
      color_lat  <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      x          <= x_n;
      y          <= y_n;
      frame_done <= last_write;
      if (load) begin
        mode_lat  <= pat_mode_e'(mode);
        w_lat     <= w;
        color_lat <= color;
      end
      if (trigger && state == ST_RUN) begin
        overrun <= 1'b1;
      end
    end
  end

  assign fifo_write = wr;
  assign busy       = (state == ST_RUN);

  pattern_pixel #(
    .XW(XW),
    .YW(YW)
`ifdef PATTERN_GEN_CHECKER_EN
    , .CHK_LOG2(CHK_LOG2)
`endif
  ) u_pixel (
    .x    (x),
    .y    (y),
    .mode (mode_lat),
    .w    (w_lat),
    .color(color_lat),
    .rgb  (fifo_data)
  );

endmodule

// File: tb/tb_pattern_gen.sv
// Scoreboard bench for pattern_gen: the driver queues expected pixels per frame,
// a monitor pops and compares on every FIFO write.
module tb_pattern_gen;

  localparam int unsigned H = 16;
  localparam int unsigned V = 8;
  localparam int N = H * V;

  logic        clk = 1'b0;
  logic        reset, trigger, fifo_full;
  logic [1:0]  mode;
  logic [11:0] w;
  logic [15:0] color;
  logic        fifo_write, busy, frame_done, overrun;
  logic [15:0] fifo_data;

  int errors = 0;
  int checks = 0;
  logic [15:0] sb[$];
  bit overrun_exp = 1'b0;

  always #5 clk = ~clk;

  pattern_gen #(.H_ACTIVE(H), .V_ACTIVE(V), .CHK_LOG2(1)) dut (
    .clk(clk), .reset(reset), .trigger(trigger), .mode(mode), .w(w),
    .color(color), .fifo_full(fifo_full), .fifo_write(fifo_write),
    .fifo_data(fifo_data), .busy(busy), .frame_done(frame_done),
    .overrun(overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model(input int m, input int wv, input logic [15:0] c,
                                         input int x, input int y);
    int r, g, b;
    case (m)
      0: return c;
      1: return (x < wv) ? c : 16'h0000;
      2: begin
`ifdef PATTERN_GEN_CHECKER_EN
        return ((((x >> 1) ^ (y >> 1)) & 1) != 0) ? ~c : c;
`else
        return c;
`endif
      end
      default: begin
        r = (x >> 3) & 31;
        g = (y >> 2) & 63;
        b = ((x >> 3) ^ (y >> 3)) & 31;
        return 16'(r * 2048 + g * 32 + b);
      end
    endcase
  endfunction

  task automatic push_frame(input int m, input int wv, input logic [15:0] c);
    for (int yy = 0; yy < int'(V); yy++)
      for (int xx = 0; xx < int'(H); xx++)
        sb.push_back(model(m, wv, c, xx, yy));
  endtask

  // Monitor: every write must be expected and must not coincide with fifo_full.
  initial begin
    logic [15:0] exp;
    forever begin
      @(negedge clk);
      if (fifo_write) begin
        check("no_write_when_full", {31'd0, fifo_full}, 32'd0);
        if (sb.size() == 0) begin
          check("unexpected_write", 32'd1, 32'd0);
        end else begin
          exp = sb.pop_front();
          check("pixel", {16'd0, fifo_data}, {16'd0, exp});
        end
      end
    end
  end

  // Called at posedge+1; leaves the bench at the next posedge+1 with params scrambled.
  task automatic start(input int m, input int wv, input logic [15:0] c);
    trigger = 1'b1;
    mode = 2'(m);
    w = 12'(wv);
    color = c;
    push_frame(m, wv, c);
    @(posedge clk); #1;
    trigger = 1'b0;
    mode = 2'($urandom);
    w = 12'($urandom);
    color = 16'($urandom);
  endtask

  task automatic run(input bit stall, input int trig_at, input bit chain,
                     input int m, input int wv, input logic [15:0] c, input int reset_at);
    int cyc = 0, busy_cnt = 0, stall_cnt = 0, last_wr = -10, done_at = -1;
    bit done = 1'b0;
    while (!done && cyc < 4 * N + 50) begin
      fifo_full = stall ? 1'($urandom_range(0, 1)) : 1'b0;
      if (cyc == trig_at) begin
        trigger = 1'b1;
        mode = 2'(m);
        w = 12'(wv);
        color = c;
        if (busy) overrun_exp = 1'b1;
        if (chain) push_frame(m, wv, c);
      end
      if (cyc == reset_at) begin
        reset = 1'b1;
        fifo_full = 1'b0;
      end
      @(negedge clk);
      if (cyc == reset_at) begin
        check("write_in_reset_cycle", {31'd0, fifo_write}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        overrun_exp = 1'b0;
        @(negedge clk);
        check("after_reset_outputs", {12'd0, fifo_write, busy, frame_done, overrun, fifo_data}, 32'd0);
        @(posedge clk); #1;
        return;
      end
      if (busy) busy_cnt++;
      if (busy && fifo_full) stall_cnt++;
      if (busy && !fifo_full) last_wr = cyc;
      if (frame_done) begin
        done = 1'b1;
        done_at = cyc;
        check("busy_low_at_done", {31'd0, busy}, 32'd0);
      end
      @(posedge clk); #1;
      trigger = 1'b0;
      cyc++;
    end
    fifo_full = 1'b0;
    check("frame_completed", {31'd0, done}, 32'd1);
    check("writes_per_frame", busy_cnt - stall_cnt, N);
    check("done_one_after_last_write", done_at - last_wr, 32'd1);
    check("overrun_flag", {31'd0, overrun}, {31'd0, overrun_exp});
    if (!done) sb.delete();
    if (!chain) begin
      check("scoreboard_drained", sb.size(), 32'd0);
      @(negedge clk);
      check("done_pulse_width", {31'd0, frame_done}, 32'd0);
      check("idle_after_frame", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset = 1'b1;
    trigger = 1'b0;
    fifo_full = 1'b0;
    mode = 2'd0;
    w = 12'd0;
    color = 16'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", {28'd0, fifo_write, busy, frame_done, overrun}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    start(0, 0, 16'hF800);    run(1'b0, -1, 1'b0, 0, 0, 16'h0, -1);
    start(1, 3, 16'h07E0);    run(1'b0, -1, 1'b0, 0, 0, 16'h0, -1);
    start(1, 0, 16'h07E0);    run(1'b0, -1, 1'b0, 0, 0, 16'h0, -1);
    start(1, 16, 16'h07E0);   run(1'b0, -1, 1'b0, 0, 0, 16'h0, -1);
    start(1, 4095, 16'h07E0); run(1'b0, -1, 1'b0, 0, 0, 16'h0, -1);
    start(0, 0, 16'h1234);    run(1'b1, -1, 1'b0, 0, 0, 16'h0, -1);
    start(3, 0, 16'hFFFF);    run(1'b1, -1, 1'b0, 0, 0, 16'h0, -1);
    start(2, 0, 16'h001F);    run(1'b0, -1, 1'b0, 0, 0, 16'h0, -1);

    // Mid-frame trigger with different params must be ignored but flagged.
    start(1, 5, 16'h1234);    run(1'b0, 7, 1'b0, 0, 0, 16'hFFFF, -1);
    // Trigger on the final write is ignored; overrun stays set.
    start(0, 0, 16'hAAAA);    run(1'b0, N - 1, 1'b0, 3, 0, 16'h0, -1);
    // Trigger in the busy-falling cycle starts the next frame.
    start(2, 0, 16'hF00F);    run(1'b0, N, 1'b1, 1, 7, 16'h001F, -1);
    run(1'b0, -1, 1'b0, 0, 0, 16'h0, -1);

    start(0, 0, 16'h5555);    run(1'b0, -1, 1'b0, 0, 0, 16'h0, 10);
    start(3, 0, 16'h0000);    run(1'b1, -1, 1'b0, 0, 0, 16'h0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
